mem_refill_ctrl: RTL and testbench
==================================

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 6, block byte-offset bits.
REQ-004 SHALL have parameter WORDS_PER_BLOCK, default 16, words per cache block.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port miss_req, input, 1, cache read miss pending.
REQ-008 SHALL have port miss_addr, input, ADDRESS_WIDTH, address of missing access.
REQ-009 SHALL have port wb_valid, input, 1, dirty victim block offered, equivalent to data_ready_main_mem.
REQ-010 SHALL have port wb_addr, input, ADDRESS_WIDTH, victim block address.
REQ-011 SHALL have port wb_data, input, DATA_WIDTH x WORDS_PER_BLOCK unpacked array, victim block.
REQ-012 SHALL have port fill_valid, output, 1, block ready, drives cache write_en_main_mem.
REQ-013 SHALL have port fill_data, output, DATA_WIDTH x WORDS_PER_BLOCK unpacked array, fetched block.
REQ-014 SHALL have port busy, output, 1, controller not IDLE.
REQ-015 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDRESS_WIDTH), mem_wdata (output, DATA_WIDTH), word-serial main-memory request.
REQ-016 SHALL have ports mem_ack (input, 1), mem_rdata (input, DATA_WIDTH), memory completion and read data.

Function
REQ-017 SHALL implement FSM states IDLE, WB, FETCH, FILL.
REQ-018 In IDLE, wb_valid=1 SHALL capture wb_addr and all wb_data words into a local buffer and enter WB next cycle.
REQ-019 In IDLE, miss_req=1 with wb_valid=0 SHALL capture miss_addr and enter FETCH next cycle.
REQ-020 In IDLE, wb_valid=1 and miss_req=1 together SHALL capture both addresses; WB runs first, then FETCH without returning to IDLE.
REQ-021 Requests arriving outside IDLE SHALL be ignored (not queued).
REQ-022 In WB/FETCH, mem_req SHALL be 1 and held with stable mem_addr/mem_we/mem_wdata until a cycle with mem_ack=1.
REQ-023 mem_ack while mem_req=0 SHALL be ignored.
REQ-024 Word counter, width clog2(WORDS_PER_BLOCK), SHALL reset to 0 on entering WB/FETCH and increment on each accepted ack.
REQ-025 mem_addr SHALL be {captured_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH], zero-extended counter at bits [OFFSET_WIDTH-1:2], 2'b00}.
REQ-026 In WB, mem_we=1 and mem_wdata=buffer[counter]; in FETCH, mem_we=0 and mem_rdata is stored to fill_data[counter] on ack.
REQ-027 Ack at counter=WORDS_PER_BLOCK-1 SHALL end the phase: WB -> FETCH if a miss was captured else IDLE; FETCH -> FILL.
REQ-028 mem_req SHALL deassert for at least one cycle between WB and FETCH phases.
REQ-029 FILL SHALL last exactly one cycle with fill_valid=1, then return to IDLE.
REQ-030 fill_data SHALL remain stable from FILL until the next FETCH stores a word.
REQ-031 busy SHALL be 1 in WB, FETCH, FILL and 0 in IDLE.
REQ-032 Minimum miss latency with single-cycle ack SHALL be miss_req -> fill_valid in WORDS_PER_BLOCK+2 cycles.

Reset
REQ-033 reset=1 SHALL immediately force IDLE, counter 0, captured-request flags 0.
REQ-034 reset SHALL force fill_valid, busy, mem_req, mem_we to 0 and mem_addr, mem_wdata, all fill_data words to 0.
REQ-035 Reset mid-transfer SHALL abort with no further mem_req until a new request after reset release.

Verification
REQ-036 Miss only, addr 0x0000_1240, ack every cycle -> 16 reads at 0x1240..0x127C, fill_valid pulse cycle 18, fill_data[k]=mem_rdata of k-th ack.
REQ-037 wb_valid only, wb_addr 0x0000_2000, wb_data[k]=k -> 16 writes 0x2000..0x203C with data 0..15, return IDLE, fill_valid never 1.
REQ-038 wb_valid and miss_req same cycle (0x2000, 0x1240) -> all writes complete, one idle-req cycle, then 16 reads, single fill_valid.
REQ-039 Ack delayed 3 cycles per word -> mem_addr/mem_wdata stable while waiting, no word skipped or duplicated.
REQ-040 Reset at word 7 of FETCH -> all outputs 0 same cycle, mem_req stays 0; miss_req after release restarts at word 0.
REQ-041 miss_req while busy, spurious mem_ack in IDLE -> both ignored, no state change.

Source files
------------

// File: rtl/mem_refill_ctrl.sv
// Cache refill controller: optional dirty-victim writeback, then word-serial block fetch and a one-cycle fill pulse.
// Miss to fill_valid is WORDS_PER_BLOCK+2 cycles at single-cycle ack; each word holds mem_req/addr/data until mem_ack.
module mem_refill_ctrl #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int OFFSET_WIDTH    = 6,
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_req,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic                     wb_valid,
    input  logic [ADDRESS_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data [WORDS_PER_BLOCK],
    output logic                     fill_valid,
    output logic [DATA_WIDTH-1:0]    fill_data [WORDS_PER_BLOCK],
    output logic                     busy,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int CNT_W  = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int WOFF_W = OFFSET_WIDTH - 2;
    localparam int TAG_W  = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    miss_pend_q, miss_pend_d;
    logic [TAG_W-1:0]        wb_tag_q, wb_tag_d;
    logic [TAG_W-1:0]        miss_tag_q, miss_tag_d;
    logic [DATA_WIDTH-1:0]   wb_buf_q [WORDS_PER_BLOCK];
    logic [DATA_WIDTH-1:0]   wb_buf_d [WORDS_PER_BLOCK];
    logic [DATA_WIDTH-1:0]   fill_q   [WORDS_PER_BLOCK];
    logic [DATA_WIDTH-1:0]   fill_d   [WORDS_PER_BLOCK];

    logic ack_ok;
    logic last_ack;
    logic unused_offset_bits;

    assign ack_ok   = mem_req_q && mem_ack;
    assign last_ack = ack_ok && (cnt_q == LAST_WORD);
    assign unused_offset_bits = ^{wb_addr[OFFSET_WIDTH-1:0], miss_addr[OFFSET_WIDTH-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    state_d = WB;
                end else if (miss_req) begin
                    state_d = FETCH;
                end
            end
            WB:      if (last_ack) state_d = miss_pend_q ? FETCH : IDLE;
            FETCH:   if (last_ack) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_req is registered so the first cycle of every phase has it low,
    // which also gives the mandatory gap between writeback and fetch.
    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        miss_pend_d = miss_pend_q;
        wb_tag_d    = wb_tag_q;
        miss_tag_d  = miss_tag_q;
        wb_buf_d    = wb_buf_q;
        fill_d      = fill_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wb_valid) begin
                    wb_tag_d    = wb_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                    wb_buf_d    = wb_data;
                    miss_pend_d = miss_req;
                    if (miss_req) miss_tag_d = miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                end else if (miss_req) begin
                    miss_tag_d  = miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                    miss_pend_d = 1'b0;
                end
            end
            WB, FETCH: begin
                mem_req_d = !last_ack;
                if (ack_ok) begin
                    cnt_d = last_ack ? '0 : cnt_q + CNT_W'(1);
                    if (state_q == FETCH) fill_d[cnt_q] = mem_rdata;
                end
                if (state_q == FETCH) miss_pend_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            miss_pend_q <= 1'b0;
            wb_tag_q    <= '0;
            miss_tag_q  <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                wb_buf_q[i] <= '0;
                fill_q[i]   <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            miss_pend_q <= miss_pend_d;
            wb_tag_q    <= wb_tag_d;
            miss_tag_q  <= miss_tag_d;
            wb_buf_q    <= wb_buf_d;
            fill_q      <= fill_d;
        end
    end

    assign fill_data = fill_q;

    always_comb begin
        fill_valid = (state_q == FILL);
        busy       = (state_q != IDLE);
        mem_req    = mem_req_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (mem_req_q) begin
            mem_addr = {(state_q == WB) ? wb_tag_q : miss_tag_q, WOFF_W'(cnt_q), 2'b00};
            if (state_q == WB) begin
                mem_we    = 1'b1;
                mem_wdata = wb_buf_q[cnt_q];
            end
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: fetch, writeback, combined, slow ack, mid-fetch reset, ignored requests.
module tb_mem_refill_ctrl;

    logic        clk;
    logic        reset;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        wb_valid;
    logic [31:0] wb_addr;
    logic [31:0] wb_data [16];
    logic        fill_valid;
    logic [31:0] fill_data [16];
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    mem_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int set, input int k);
        return 32'(set) * 32'h0001_0000 + 32'hA000_0000 + 32'(k) * 32'h11;
    endfunction

    initial begin
        reset     = 1'b1;
        miss_req  = 1'b0;
        miss_addr = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) wb_data[i] = '0;

        // reset state
        tick(); #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_fill0", fill_data[0], 32'd0);
        tick(); reset = 1'b0; #3;

        // miss only, single-cycle ack
        tick(); miss_req = 1'b1; miss_addr = 32'h0000_1240; t0 = cyc; #3;
        chk("m_idle_busy", {31'd0, busy}, 32'd0);
        tick(); miss_req = 1'b0; #3;
        chk("m_busy", {31'd0, busy}, 32'd1);
        chk("m_gap_req", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick(); mem_ack = 1'b1; mem_rdata = rd(1, k); #3;
            chk("m_req", {31'd0, mem_req}, 32'd1);
            chk("m_we", {31'd0, mem_we}, 32'd0);
            chk("m_addr", mem_addr, 32'h0000_1240 + 32'(4 * k));
        end
        tick(); mem_ack = 1'b0; #3;
        chk("m_fill_valid", {31'd0, fill_valid}, 32'd1);
        chk("m_latency", 32'(cyc - t0), 32'd18);
        for (int k = 0; k < 16; k++) chk("m_fill_data", fill_data[k], rd(1, k));
        tick(); #3;
        chk("m_fill_end", {31'd0, fill_valid}, 32'd0);
        chk("m_idle", {31'd0, busy}, 32'd0);

        // writeback only
        tick(); wb_valid = 1'b1; wb_addr = 32'h0000_2000;
        for (int i = 0; i < 16; i++) wb_data[i] = 32'(i);
        #3;
        tick(); wb_valid = 1'b0;
        for (int i = 0; i < 16; i++) wb_data[i] = 32'hFFFF_FFFF;
        #3;
        chk("w_busy", {31'd0, busy}, 32'd1);
        chk("w_gap_req", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick(); mem_ack = 1'b1; #3;
            chk("w_req", {31'd0, mem_req}, 32'd1);
            chk("w_we", {31'd0, mem_we}, 32'd1);
            chk("w_addr", mem_addr, 32'h0000_2000 + 32'(4 * k));
            chk("w_wdata", mem_wdata, 32'(k));
            chk("w_no_fill", {31'd0, fill_valid}, 32'd0);
        end
        tick(); mem_ack = 1'b0; #3;
        chk("w_idle", {31'd0, busy}, 32'd0);
        chk("w_req_off", {31'd0, mem_req}, 32'd0);
        chk("w_no_fill_end", {31'd0, fill_valid}, 32'd0);
        chk("w_fill_kept", fill_data[3], rd(1, 3));

        // writeback and miss together
        tick(); wb_valid = 1'b1; miss_req = 1'b1;
        wb_addr = 32'h0000_2000; miss_addr = 32'h0000_1240;
        for (int i = 0; i < 16; i++) wb_data[i] = 32'h100 + 32'(i);
        #3;
        tick(); wb_valid = 1'b0; miss_req = 1'b0; #3;
        chk("c_gap0", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick(); mem_ack = 1'b1; #3;
            chk("c_we", {31'd0, mem_we}, 32'd1);
            chk("c_waddr", mem_addr, 32'h0000_2000 + 32'(4 * k));
            chk("c_wdata", mem_wdata, 32'h100 + 32'(k));
        end
        tick(); mem_ack = 1'b0; #3;
        chk("c_gap_req", {31'd0, mem_req}, 32'd0);
        chk("c_gap_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick(); mem_ack = 1'b1; mem_rdata = rd(2, k); #3;
            chk("c_rreq", {31'd0, mem_req}, 32'd1);
            chk("c_rwe", {31'd0, mem_we}, 32'd0);
            chk("c_raddr", mem_addr, 32'h0000_1240 + 32'(4 * k));
            chk("c_no_early_fill", {31'd0, fill_valid}, 32'd0);
        end
        tick(); mem_ack = 1'b0; #3;
        chk("c_fill_valid", {31'd0, fill_valid}, 32'd1);
        chk("c_fill0", fill_data[0], rd(2, 0));
        chk("c_fill15", fill_data[15], rd(2, 15));
        tick(); #3;
        chk("c_single_fill", {31'd0, fill_valid}, 32'd0);
        chk("c_idle", {31'd0, busy}, 32'd0);

        // slow ack (3 wait cycles per word) with a miss_req held while busy
        tick(); miss_req = 1'b1; miss_addr = 32'h0000_3080; #3;
        tick(); miss_addr = 32'h0000_5540; #3;
        chk("s_gap_req", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 3; w++) begin
                tick(); mem_ack = 1'b0; #3;
                chk("s_wait_req", {31'd0, mem_req}, 32'd1);
                chk("s_wait_addr", mem_addr, 32'h0000_3080 + 32'(4 * k));
                if (k == 0 && w == 2) miss_req = 1'b0;
            end
            tick(); mem_ack = 1'b1; mem_rdata = rd(3, k); #3;
            chk("s_ack_addr", mem_addr, 32'h0000_3080 + 32'(4 * k));
        end
        tick(); mem_ack = 1'b0; #3;
        chk("s_fill_valid", {31'd0, fill_valid}, 32'd1);
        for (int k = 0; k < 16; k++) chk("s_fill_data", fill_data[k], rd(3, k));
        tick(); #3;
        chk("s_idle", {31'd0, busy}, 32'd0);
        tick(); #3;
        chk("s_stays_idle", {31'd0, busy}, 32'd0);
        chk("s_no_req", {31'd0, mem_req}, 32'd0);

        // reset at word 7 of a fetch
        tick(); miss_req = 1'b1; miss_addr = 32'h0000_1240; #3;
        tick(); miss_req = 1'b0; #3;
        for (int k = 0; k < 7; k++) begin
            tick(); mem_ack = 1'b1; mem_rdata = rd(4, k); #3;
        end
        tick(); mem_ack = 1'b0; #1;
        chk("r_word7_addr", mem_addr, 32'h0000_125C);
        reset = 1'b1; #1;
        chk("r_req", {31'd0, mem_req}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_we", {31'd0, mem_we}, 32'd0);
        chk("r_addr", mem_addr, 32'd0);
        chk("r_wdata", mem_wdata, 32'd0);
        chk("r_fill_valid", {31'd0, fill_valid}, 32'd0);
        chk("r_fill0", fill_data[0], 32'd0);
        chk("r_fill15", fill_data[15], 32'd0);
        tick(); reset = 1'b0; #3;
        for (int i = 0; i < 3; i++) begin
            tick(); #3;
            chk("r_quiet_req", {31'd0, mem_req}, 32'd0);
        end
        tick(); miss_req = 1'b1; #3;
        tick(); miss_req = 1'b0; #3;
        chk("r2_gap_req", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick(); mem_ack = 1'b1; mem_rdata = rd(5, k); #3;
            chk("r2_addr", mem_addr, 32'h0000_1240 + 32'(4 * k));
        end
        tick(); mem_ack = 1'b0; #3;
        chk("r2_fill_valid", {31'd0, fill_valid}, 32'd1);
        chk("r2_fill7", fill_data[7], rd(5, 7));
        tick(); #3;

        // spurious ack in IDLE
        tick(); mem_ack = 1'b1; #3;
        chk("i_busy", {31'd0, busy}, 32'd0);
        chk("i_req", {31'd0, mem_req}, 32'd0);
        tick(); mem_ack = 1'b0; #3;
        chk("i_busy2", {31'd0, busy}, 32'd0);
        chk("i_fill_kept", fill_data[7], rd(5, 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
